// File: rtl/wb_regfile_scoreboard.sv
// Writeback-side integer register file with write-first bypass and a
// per-register in-flight counter that drives the decode stall.
module wb_regfile_scoreboard #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int PEND_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rd_addr_i,
  input  logic [XLEN-1:0] rd_data_i,
  input  logic            rd_wen_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            rs1_use_i,
  input  logic            rs2_use_i,
  input  logic            issue_i,
  input  logic [4:0]      issue_rd_addr_i,
  input  logic            issue_rd_wen_i,
  output logic            hazard_stall_o
);

  localparam logic [PEND_W-1:0] PMAX = '1;
  localparam logic [PEND_W-1:0] PONE = PEND_W'(1);

  logic [XLEN-1:0]   r_regs [NREG];
  logic [PEND_W-1:0] r_pend [NREG];

  logic              w_wb_dec;
  logic              w_wb_rs1;
  logic              w_wb_rs2;
  logic              w_wb_ird;
  logic [PEND_W-1:0] w_p1;
  logic [PEND_W-1:0] w_p2;
  logic [PEND_W-1:0] w_pd;
  logic              w_src1_haz;
  logic              w_src2_haz;
  logic              w_dst_full;
  logic              w_inc;

  assign w_wb_dec = rd_wen_i && (rd_addr_i != 5'd0);
  assign w_wb_rs1 = w_wb_dec && (rd_addr_i == rs1_addr_i);
  assign w_wb_rs2 = w_wb_dec && (rd_addr_i == rs2_addr_i);
  assign w_wb_ird = w_wb_dec && (rd_addr_i == issue_rd_addr_i);

  assign w_p1 = r_pend[rs1_addr_i];
  assign w_p2 = r_pend[rs2_addr_i];
  assign w_pd = r_pend[issue_rd_addr_i];

  // A writeback landing now retires one in-flight write before the check.
  assign w_src1_haz = rs1_use_i && (rs1_addr_i != 5'd0) &&
                      (w_wb_rs1 ? (w_p1 > PONE) : (w_p1 != '0));
  assign w_src2_haz = rs2_use_i && (rs2_addr_i != 5'd0) &&
                      (w_wb_rs2 ? (w_p2 > PONE) : (w_p2 != '0));
  assign w_dst_full = issue_rd_wen_i && (issue_rd_addr_i != 5'd0) &&
                      (w_pd == PMAX) && !w_wb_ird;

  assign hazard_stall_o = issue_i && (w_src1_haz || w_src2_haz || w_dst_full);

  assign w_inc = issue_i && !hazard_stall_o && issue_rd_wen_i &&
                 (issue_rd_addr_i != 5'd0);

  always_comb begin
    rs1_data_o = r_regs[rs1_addr_i];
    rs2_data_o = r_regs[rs2_addr_i];
    if (rs1_addr_i == 5'd0)
      rs1_data_o = '0;
    else if (rd_wen_i && (rd_addr_i == rs1_addr_i))
      rs1_data_o = rd_data_i;
    if (rs2_addr_i == 5'd0)
      rs2_data_o = '0;
    else if (rd_wen_i && (rd_addr_i == rs2_addr_i))
      rs2_data_o = rd_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
        r_pend[i] <= '0;
      end
    end else begin
      if (w_wb_dec)
        r_regs[rd_addr_i] <= rd_data_i;
      for (int i = 1; i < NREG; i++) begin
        if (w_inc && (issue_rd_addr_i == i[4:0]) &&
            !(w_wb_dec && (rd_addr_i == i[4:0])))
          r_pend[i] <= r_pend[i] + PONE;
        else if (w_wb_dec && (rd_addr_i == i[4:0]) &&
                 !(w_inc && (issue_rd_addr_i == i[4:0])) &&
                 (r_pend[i] != '0))
          r_pend[i] <= r_pend[i] - PONE;
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed bench for wb_regfile_scoreboard: a count-based model of
// in-flight writes checked every cycle plus literal spot checks.
module tb_wb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr_i;
  logic [63:0] rd_data_i;
  logic        rd_wen_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic [63:0] rs1_data_o;
  logic [63:0] rs2_data_o;
  logic        rs1_use_i;
  logic        rs2_use_i;
  logic        issue_i;
  logic [4:0]  issue_rd_addr_i;
  logic        issue_rd_wen_i;
  logic        hazard_stall_o;

  int n_vec = 0;
  int n_bad = 0;

  logic [63:0] m_regs [32];
  int          m_pend [32];
  bit          m_valid = 1'b0;

  always #5 clk = ~clk;

  wb_regfile_scoreboard dut (
    .clk             (clk),
    .rst             (rst),
    .rd_addr_i       (rd_addr_i),
    .rd_data_i       (rd_data_i),
    .rd_wen_i        (rd_wen_i),
    .rs1_addr_i      (rs1_addr_i),
    .rs2_addr_i      (rs2_addr_i),
    .rs1_data_o      (rs1_data_o),
    .rs2_data_o      (rs2_data_o),
    .rs1_use_i       (rs1_use_i),
    .rs2_use_i       (rs2_use_i),
    .issue_i         (issue_i),
    .issue_rd_addr_i (issue_rd_addr_i),
    .issue_rd_wen_i  (issue_rd_wen_i),
    .hazard_stall_o  (hazard_stall_o)
  );

  function automatic bit m_wb();
    return rd_wen_i && rd_addr_i != 0;
  endfunction

  // Writes still outstanding on r once any landing writeback retires.
  function automatic int m_left(input logic [4:0] r);
    if (r == 0) return 0;
    return m_pend[r] - ((m_wb() && rd_addr_i == r) ? 1 : 0);
  endfunction

  function automatic bit m_stall();
    bit s1, s2, d;
    s1 = rs1_use_i && m_left(rs1_addr_i) > 0;
    s2 = rs2_use_i && m_left(rs2_addr_i) > 0;
    d  = issue_rd_wen_i && issue_rd_addr_i != 0 &&
         m_left(issue_rd_addr_i) >= 3;
    return issue_i && (s1 || s2 || d);
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] a);
    if (a == 0) return 64'd0;
    if (rd_wen_i && rd_addr_i == a) return rd_data_i;
    return m_regs[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 64'd0;
        m_pend[i] = 0;
      end
      m_valid = 1'b1;
    end else if (m_valid) begin
      bit inc;
      inc = issue_i && !m_stall() && issue_rd_wen_i && issue_rd_addr_i != 0;
      assert (!(m_wb() && m_pend[rd_addr_i] == 0))
        else $error("protocol: writeback to x%0d with no write in flight",
                    rd_addr_i);
      if (m_wb()) m_regs[rd_addr_i] = rd_data_i;
      if (inc) m_pend[issue_rd_addr_i] += 1;
      if (m_wb() && m_pend[rd_addr_i] > 0) m_pend[rd_addr_i] -= 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model rs1_data", rs1_data_o, m_read(rs1_addr_i));
      chk("model rs2_data", rs2_data_o, m_read(rs2_addr_i));
      chk("model stall", 64'(hazard_stall_o), 64'(m_stall()));
    end
  end

  task automatic idle();
    rd_addr_i = 0; rd_data_i = 0; rd_wen_i = 0;
    rs1_addr_i = 0; rs2_addr_i = 0; rs1_use_i = 0; rs2_use_i = 0;
    issue_i = 0; issue_rd_addr_i = 0; issue_rd_wen_i = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue_rd(input logic [4:0] r);
    issue_i = 1; issue_rd_addr_i = r; issue_rd_wen_i = 1;
  endtask

  task automatic wb(input logic [4:0] r, input logic [63:0] d);
    rd_wen_i = 1; rd_addr_i = r; rd_data_i = d;
  endtask

  initial begin
    idle();
    rst = 1;
    nxt();
    rst = 0;
    // Reset then read.
    rs1_addr_i = 5; rs2_addr_i = 31; rs1_use_i = 1; rs2_use_i = 1;
    issue_i = 1;
    @(negedge clk);
    chk("reset rs1", rs1_data_o, 64'd0);
    chk("reset rs2", rs2_data_o, 64'd0);
    chk("reset stall", 64'(hazard_stall_o), 64'd0);
    nxt();
    // Write then read.
    issue_rd(3);
    nxt();
    wb(3, 64'hDEAD_BEEF_0000_0001);
    nxt();
    rs1_addr_i = 3;
    @(negedge clk);
    chk("write-read rs1", rs1_data_o, 64'hDEAD_BEEF_0000_0001);
    nxt();
    // Same-cycle bypass.
    issue_rd(7);
    nxt();
    wb(7, 64'h55); rs2_addr_i = 7;
    @(negedge clk);
    chk("bypass rs2", rs2_data_o, 64'h55);
    nxt();
    rs2_addr_i = 7;
    @(negedge clk);
    chk("array rs2", rs2_data_o, 64'h55);
    nxt();
    // x0 rules.
    wb(0, 64'hFF); rs1_addr_i = 0;
    @(negedge clk);
    chk("x0 bypass rs1", rs1_data_o, 64'd0);
    nxt();
    rs1_addr_i = 0;
    issue_rd(0); rs1_use_i = 1;
    @(negedge clk);
    chk("x0 read rs1", rs1_data_o, 64'd0);
    chk("x0 issue stall", 64'(hazard_stall_o), 64'd0);
    nxt();
    chk("x0 pend", 64'(m_pend[0]), 64'd0);
    // RAW stall and writeback release.
    issue_rd(4);
    nxt();
    issue_i = 1; rs1_addr_i = 4; rs1_use_i = 1;
    @(negedge clk);
    chk("raw stall", 64'(hazard_stall_o), 64'd1);
    nxt();
    issue_i = 1; rs1_addr_i = 4; rs1_use_i = 1; wb(4, 64'h9);
    @(negedge clk);
    chk("raw release stall", 64'(hazard_stall_o), 64'd0);
    chk("raw release rs1", rs1_data_o, 64'h9);
    nxt();
    // Simultaneous issue/writeback and saturation on x9.
    issue_rd(9);
    nxt();
    issue_rd(9); wb(9, 64'h1);
    nxt();
    chk("x9 pend simul", 64'(m_pend[9]), 64'd1);
    issue_rd(9);
    nxt();
    issue_rd(9);
    nxt();
    chk("x9 pend sat", 64'(m_pend[9]), 64'd3);
    issue_rd(9);
    @(negedge clk);
    chk("x9 full stall", 64'(hazard_stall_o), 64'd1);
    nxt();
    chk("x9 pend held", 64'(m_pend[9]), 64'd3);
    issue_rd(9); wb(9, 64'h2);
    @(negedge clk);
    chk("x9 full+wb stall", 64'(hazard_stall_o), 64'd0);
    nxt();
    chk("x9 pend full+wb", 64'(m_pend[9]), 64'd3);
    for (int k = 0; k < 3; k++) begin
      wb(9, 64'(k + 16));
      nxt();
    end
    issue_i = 1; rs1_addr_i = 9; rs1_use_i = 1;
    @(negedge clk);
    chk("x9 drained stall", 64'(hazard_stall_o), 64'd0);
    chk("x9 drained rs1", rs1_data_o, 64'd18);
    nxt();
    // rs2 source hazard, masked when rs2 is unused.
    issue_rd(20);
    nxt();
    issue_i = 1; rs2_addr_i = 20; rs2_use_i = 1;
    @(negedge clk);
    chk("rs2 stall", 64'(hazard_stall_o), 64'd1);
    nxt();
    issue_i = 1; rs2_addr_i = 20;
    @(negedge clk);
    chk("rs2 unused stall", 64'(hazard_stall_o), 64'd0);
    nxt();
    // Reset mid-operation drops in-flight state and data.
    issue_rd(12);
    nxt();
    rst = 1;
    nxt();
    rst = 0;
    issue_i = 1; rs1_addr_i = 12; rs1_use_i = 1;
    rs2_addr_i = 3; rs2_use_i = 1;
    @(negedge clk);
    chk("post-reset stall", 64'(hazard_stall_o), 64'd0);
    chk("post-reset rs2", rs2_data_o, 64'd0);
    nxt();
    nxt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
